// File: rtl/rf_pkg.sv
// Shared constants and types for the 2-read / 1-write integer register file.
// Optional feature macro used by the file set: RF_BYPASS_EN (write-through forwarding).
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

    localparam logic [RF_ADDR_W-1:0] RF_X0_ADDR = 5'd0;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register file access bundle: one write port (rd) and two read ports (rs1/rs2).
// Write side is sampled on the clock edge; read data is combinational from the read addresses.
interface regfile_2r1w_if
    import rf_pkg::*;
#(
    parameter int DW = RF_DATA_W,
    parameter int AW = RF_ADDR_W
) ();

    logic          RF_WrEn;
    logic [AW-1:0] RF_WrAddr;
    logic [DW-1:0] RF_WrData;
    logic [AW-1:0] RF_RdAddrA;
    logic [AW-1:0] RF_RdAddrB;
    logic [DW-1:0] RF_RdDataA;
    logic [DW-1:0] RF_RdDataB;

    // Requester side (decode/writeback stages).
    modport master (
        output RF_WrEn, RF_WrAddr, RF_WrData, RF_RdAddrA, RF_RdAddrB,
        input  RF_RdDataA, RF_RdDataB
    );

    // Register file side.
    modport slave (
        input  RF_WrEn, RF_WrAddr, RF_WrData, RF_RdAddrA, RF_RdAddrB,
        output RF_RdDataA, RF_RdDataB
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: entry mux, x0 zero-forcing and, when RF_BYPASS_EN is
// defined, same-cycle forwarding of the pending write.
module rf_read_port
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [2**AW-1:0][DW-1:0] i_entries,
    input  logic [AW-1:0]            i_rd_addr,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [DW-1:0]            i_wr_data,
    output logic [DW-1:0]            o_rd_data
);

    logic w_is_x0;
    assign w_is_x0 = (i_rd_addr == '0);

`ifdef RF_BYPASS_EN
    // A write to x0 is discarded, so it must never be forwarded either.
    logic w_bypass_hit;
    assign w_bypass_hit = i_wr_en && (i_wr_addr != '0) && (i_wr_addr == i_rd_addr);

    always_comb begin
        o_rd_data = i_entries[i_rd_addr];
        if (w_is_x0) begin
            o_rd_data = '0;
        end else if (w_bypass_hit) begin
            o_rd_data = i_wr_data;
        end
    end
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};

    always_comb begin
        o_rd_data = i_entries[i_rd_addr];
        if (w_is_x0) begin
            o_rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile_2r1w.sv
// RISC-V integer register file, 2 combinational reads and 1 clocked write, x0 hardwired to 0.
// Define RF_BYPASS_EN for write-through forwarding on same-address read/write.
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int                       RF_DATA_WIDTH  = RF_DATA_W,
    parameter int                       RF_ADDR_WIDTH  = RF_ADDR_W,
    parameter logic [RF_DATA_WIDTH-1:0] RF_RESET_VALUE = '0
) (
    input  logic           RF_Clk,
    input  logic           RF_Reset,
    regfile_2r1w_if.slave  bus
);

    localparam int DEPTH = 2 ** RF_ADDR_WIDTH;

    logic [DEPTH-1:0][RF_DATA_WIDTH-1:0] w_entries;
    logic [DEPTH-1:1]                    w_wr_sel;
    logic [RF_DATA_WIDTH-1:0]            w_rd_a;
    logic [RF_DATA_WIDTH-1:0]            w_rd_b;

    // Address 0 has no select line, so x0 writes fall away here.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_wr_sel[i] = bus.RF_WrEn && (bus.RF_WrAddr == RF_ADDR_WIDTH'(i));
        end
    end

    assign w_entries[0] = '0;

    generate
        for (genvar g = 1; g < DEPTH; g++) begin : g_entry
            logic [RF_DATA_WIDTH-1:0] r_data;

            always_ff @(posedge RF_Clk or negedge RF_Reset) begin
                if (!RF_Reset) begin
                    r_data <= RF_RESET_VALUE;
                end else if (w_wr_sel[g]) begin
                    r_data <= bus.RF_WrData;
                end
            end

            assign w_entries[g] = r_data;
        end
    endgenerate

    rf_read_port #(
        .DW (RF_DATA_WIDTH),
        .AW (RF_ADDR_WIDTH)
    ) u_port_a (
        .i_entries (w_entries),
        .i_rd_addr (bus.RF_RdAddrA),
        .i_wr_en   (bus.RF_WrEn),
        .i_wr_addr (bus.RF_WrAddr),
        .i_wr_data (bus.RF_WrData),
        .o_rd_data (w_rd_a)
    );

    rf_read_port #(
        .DW (RF_DATA_WIDTH),
        .AW (RF_ADDR_WIDTH)
    ) u_port_b (
        .i_entries (w_entries),
        .i_rd_addr (bus.RF_RdAddrB),
        .i_wr_en   (bus.RF_WrEn),
        .i_wr_addr (bus.RF_WrAddr),
        .i_wr_data (bus.RF_WrData),
        .o_rd_data (w_rd_b)
    );

    assign bus.RF_RdDataA = w_rd_a;
    assign bus.RF_RdDataB = w_rd_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: reset sweep, vector table, hand corner sequences and random
// traffic against an array model of the architectural register state.
module tb_regfile_2r1w;
    import rf_pkg::*;

    localparam rf_data_t RV = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_2r1w_if #(.DW(32), .AW(5)) bus ();

    regfile_2r1w #(
        .RF_DATA_WIDTH  (32),
        .RF_ADDR_WIDTH  (5),
        .RF_RESET_VALUE (RV)
    ) dut (
        .RF_Clk   (clk),
        .RF_Reset (rst_n),
        .bus      (bus)
    );

    rf_data_t model [32];
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic     we;
        rf_addr_t wa;
        rf_data_t wd;
        rf_addr_t ra;
        rf_addr_t rb;
        rf_data_t ea;
        rf_data_t eb;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input rf_data_t act, input rf_data_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 0) ? 32'h0 : RV;
    endtask

    // Architectural read as seen before the clock edge that would commit (we, wa, wd).
    function automatic rf_data_t exp_rd(input rf_addr_t ra, input logic we,
                                        input rf_addr_t wa, input rf_data_t wd);
        if (ra == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (we && wa == ra) return wd;
`else
        if (we && wa == ra && wd == 32'h0) return model[ra];
`endif
        return model[ra];
    endfunction

    task automatic drive(input logic we, input rf_addr_t wa, input rf_data_t wd,
                         input rf_addr_t ra, input rf_addr_t rb);
        bus.RF_WrEn    = we;
        bus.RF_WrAddr  = wa;
        bus.RF_WrData  = wd;
        bus.RF_RdAddrA = ra;
        bus.RF_RdAddrB = rb;
    endtask

    task automatic commit(input logic we, input rf_addr_t wa, input rf_data_t wd);
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) model[wa] = wd;
    endtask

    task automatic cycle(input logic we, input rf_addr_t wa, input rf_data_t wd,
                         input rf_addr_t ra, input rf_addr_t rb, input string tag);
        @(negedge clk);
        drive(we, wa, wd, ra, rb);
        #1;
        check({tag, "_a"}, bus.RF_RdDataA, exp_rd(ra, we, wa, wd));
        check({tag, "_b"}, bus.RF_RdDataB, exp_rd(rb, we, wa, wd));
        commit(we, wa, wd);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.we, v.wa, v.wd, v.ra, v.rb);
        #1;
        check($sformatf("vec%0d_a", idx), bus.RF_RdDataA, v.ea);
        check($sformatf("vec%0d_b", idx), bus.RF_RdDataB, v.eb);
        commit(v.we, v.wa, v.wd);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd9,  32'h000055AA, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'h000055AA, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd31, 32'h80000001, 5'd30, 5'd1,  32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h80000001, 32'h80000001};
        vecs[8] = '{1'b0, 5'd9,  32'h0000FFFF, 5'd9,  5'd31, 32'h000055AA, 32'h80000001};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  32'h000055AA, 32'h0};

        model_reset();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Reset held across clock edges: every address reads the reset contents.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, rf_addr_t'(i), 32'hCAFE0000, rf_addr_t'(i), rf_addr_t'(31 - i));
            #1;
            check("rst_sweep_a", bus.RF_RdDataA, 32'h0);
            check("rst_sweep_b", bus.RF_RdDataB, 32'h0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

        // Same-cycle write and read of x7.
        cycle(1'b1, 5'd7, 32'h1, 5'd0, 5'd0, "pre7");
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
        #1;
`ifdef RF_BYPASS_EN
        check("same_cycle_a", bus.RF_RdDataA, 32'h12345678);
        check("same_cycle_b", bus.RF_RdDataB, 32'h12345678);
`else
        check("same_cycle_a", bus.RF_RdDataA, 32'h1);
        check("same_cycle_b", bus.RF_RdDataB, 32'h1);
`endif
        commit(1'b1, 5'd7, 32'h12345678);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
        #1;
        check("after_edge_a", bus.RF_RdDataA, 32'h12345678);

        // Asynchronous reset pulse inside the low clock phase.
        cycle(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, "wr3");
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        #1;
        check("x3_before_rst", bus.RF_RdDataA, 32'hA5A5A5A5);
        #1 rst_n = 1'b0;
        #1;
        check("x3_async_rst", bus.RF_RdDataA, 32'h0);
        check("x5_async_rst", bus.RF_RdDataB, 32'h0);
        #1 rst_n = 1'b1;
        model_reset();

        // Reset held over an edge with a write pending: the write is lost.
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h00001111, 5'd0, 5'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd4, 32'h00002222, 5'd4, 5'd0);
        #1;
`ifdef RF_BYPASS_EN
        check("rst_wins_x4", bus.RF_RdDataA, 32'h00002222);
`else
        check("rst_wins_x4", bus.RF_RdDataA, 32'h0);
`endif
        commit(1'b1, 5'd4, 32'h00002222);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        #1;
        check("first_write_a", bus.RF_RdDataA, 32'h00002222);
        check("first_write_b", bus.RF_RdDataB, 32'h00002222);

        // Back-to-back writes x1..x31 = addr*3, then read mirrored pairs.
        for (int a = 1; a < 32; a++) cycle(1'b1, rf_addr_t'(a), rf_data_t'(a * 3), 5'd0, 5'd0, "b2b_wr");
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, rf_addr_t'(i), rf_addr_t'(31 - i));
            #1;
            check("pair_a", bus.RF_RdDataA, rf_data_t'(i * 3));
            check("pair_b", bus.RF_RdDataB, rf_data_t'((31 - i) * 3));
        end

        // Random traffic, biased so reads often hit the address being written.
        for (int n = 0; n < 400; n++) begin
            logic     we;
            rf_addr_t wa, ra, rb;
            rf_data_t wd;
            we = 1'($urandom_range(0, 1));
            wa = rf_addr_t'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : rf_addr_t'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : rf_addr_t'($urandom_range(0, 31));
            cycle(we, wa, wd, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
